// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one downstream memory port between the instruction
// bus and the data bus. Dbus wins contention until a saturating starve counter
// reaches STARVE_LIMIT, at which point ibus is forced through. The granted
// request is latched and held downstream until cbus_data_ok. A mandatory IDLE
// cycle follows every completion so a held upstream request is never reissued.
module core_mem_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction bus
  input  logic                  ireq_valid,
  input  logic [ADDR_W-1:0]     ireq_addr,
  output logic                  iresp_data_ok,
  output logic [DATA_W-1:0]     iresp_data,
  // data bus
  input  logic                  dreq_valid,
  input  logic [ADDR_W-1:0]     dreq_addr,
  input  logic [2:0]            dreq_size,
  input  logic [DATA_W-1:0]     dreq_data,
  input  logic [DATA_W/8-1:0]   dreq_strobe,
  output logic                  dresp_data_ok,
  output logic [DATA_W-1:0]     dresp_data,
  // downstream port
  output logic                  cbus_valid,
  output logic [ADDR_W-1:0]     cbus_addr,
  output logic [2:0]            cbus_size,
  output logic [DATA_W-1:0]     cbus_wdata,
  output logic [DATA_W/8-1:0]   cbus_strobe,
  output logic                  cbus_owner,
  input  logic                  cbus_data_ok,
  input  logic [DATA_W-1:0]     cbus_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [2:0]       MSIZE_4B = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_q;
  logic                valid_q;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strobe_q;
  logic [CNT_W-1:0]    starve_q;

  logic                grant_d;
  logic                grant_i;
  logic [CNT_W-1:0]    starve_d;

  // Arbitration decision and next starve count for the IDLE sampling cycle
  always_comb begin
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (dreq_valid && (!ireq_valid || (starve_q < LIMIT))) begin
        grant_d = 1'b1;
        if (ireq_valid) begin
          starve_d = (starve_q < LIMIT) ? (starve_q + CNT_W'(1)) : LIMIT;
        end
      end else if (ireq_valid) begin
        grant_i  = 1'b1;
        starve_d = '0;
      end
    end
  end

  // Arbiter FSM: grant and latch in IDLE, hold the request until completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      starve_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (grant_d) begin
            state_q  <= BUSY_D;
            valid_q  <= 1'b1;
            owner_q  <= 1'b1;
            addr_q   <= dreq_addr;
            size_q   <= dreq_size;
            wdata_q  <= dreq_data;
            strobe_q <= dreq_strobe;
          end else if (grant_i) begin
            state_q  <= BUSY_I;
            valid_q  <= 1'b1;
            owner_q  <= 1'b0;
            addr_q   <= ireq_addr;
            size_q   <= MSIZE_4B;
            wdata_q  <= '0;
            strobe_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (cbus_data_ok) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Downstream request is driven only from the latched copy
  assign cbus_valid  = valid_q;
  assign cbus_owner  = owner_q;
  assign cbus_addr   = addr_q;
  assign cbus_size   = size_q;
  assign cbus_wdata  = wdata_q;
  assign cbus_strobe = strobe_q;

  // Completion is routed to the owner in the same cycle; stray completions in IDLE are dropped
  assign iresp_data_ok = (state_q == BUSY_I) && cbus_data_ok;
  assign dresp_data_ok = (state_q == BUSY_D) && cbus_data_ok;
  assign iresp_data    = cbus_rdata;
  assign dresp_data    = cbus_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter with grant/response scoreboards.
module tb_core_mem_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic              clk;
  logic              reset;
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_data_ok;
  logic [DATA_W-1:0] iresp_data;
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [DATA_W-1:0] dreq_data;
  logic [7:0]        dreq_strobe;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;
  logic              cbus_valid;
  logic [ADDR_W-1:0] cbus_addr;
  logic [2:0]        cbus_size;
  logic [DATA_W-1:0] cbus_wdata;
  logic [7:0]        cbus_strobe;
  logic              cbus_owner;
  logic              cbus_data_ok;
  logic [DATA_W-1:0] cbus_rdata;

  core_mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_data    (dreq_data),
    .dreq_strobe  (dreq_strobe),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .cbus_valid   (cbus_valid),
    .cbus_addr    (cbus_addr),
    .cbus_size    (cbus_size),
    .cbus_wdata   (cbus_wdata),
    .cbus_strobe  (cbus_strobe),
    .cbus_owner   (cbus_owner),
    .cbus_data_ok (cbus_data_ok),
    .cbus_rdata   (cbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic prev_valid = 1'b0;
  logic [159:0] exp_grant[$];
  logic [159:0] exp_resp[$];

  function automatic logic [159:0] gv(input logic o, input logic [63:0] a,
                                      input logic [2:0] s, input logic [7:0] st,
                                      input logic [63:0] w);
    return 160'({o, a, s, st, w});
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard checks on new grants and on upstream completions
  task automatic monitor();
    if (cbus_valid && !prev_valid) begin
      if (exp_grant.size() == 0) chk("unexpected_grant", 160'(cbus_valid), 160'(0));
      else chk("grant", gv(cbus_owner, cbus_addr, cbus_size, cbus_strobe, cbus_wdata),
               exp_grant.pop_front());
    end
    prev_valid = cbus_valid;
    if (iresp_data_ok || dresp_data_ok) begin
      chk("dual_data_ok", 160'(iresp_data_ok & dresp_data_ok), 160'(0));
      if (exp_resp.size() == 0)
        chk("unexpected_resp", 160'({iresp_data_ok, dresp_data_ok}), 160'(0));
      else
        chk("resp", 160'({dresp_data_ok, dresp_data_ok ? dresp_data : iresp_data}),
            exp_resp.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input int k, input logic [63:0] rd, input logic own);
    repeat (k - 1) step();
    cbus_rdata   = rd;
    cbus_data_ok = 1'b1;
    exp_resp.push_back(160'({own, rd}));
    step();
    cbus_data_ok = 1'b0;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!cbus_valid && n < 10) begin
      step();
      n++;
    end
    if (!cbus_valid) chk("grant_timeout", 160'(cbus_valid), 160'(1));
  endtask

  logic own_seq [6];
  int   n;

  initial begin
    reset = 1'b1; ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_data = '0; dreq_strobe = '0;
    cbus_data_ok = 1'b0; cbus_rdata = '0;
    own_seq[0] = 1'b1; own_seq[1] = 1'b1; own_seq[2] = 1'b0;
    own_seq[3] = 1'b1; own_seq[4] = 1'b1; own_seq[5] = 1'b0;
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 160'(cbus_valid), 160'(0));
    chk("rst_req", gv(cbus_owner, cbus_addr, cbus_size, cbus_strobe, cbus_wdata), 160'(0));
    chk("rst_ok", 160'({iresp_data_ok, dresp_data_ok}), 160'(0));

    // Ibus only: grant at t1, completion at t3, idle at t4
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
    exp_grant.push_back(gv(1'b0, 64'h8000_0000, 3'd2, 8'h00, 64'h0));
    step();
    ireq_valid = 1'b0;
    chk("t1_req", 160'({cbus_valid, cbus_owner, cbus_addr, cbus_size, cbus_strobe}),
        160'({1'b1, 1'b0, 64'h8000_0000, 3'd2, 8'h00}));
    step();
    respond(1, 64'h13, 1'b0);
    chk("t4_valid", 160'(cbus_valid), 160'(0));

    // Contention with counter 0: dbus write first, then ibus after one idle cycle
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
    dreq_valid = 1'b1; dreq_addr = 64'h8010_0008; dreq_size = 3'd3;
    dreq_data = 64'hDEAD_BEEF; dreq_strobe = 8'hFF;
    exp_grant.push_back(gv(1'b1, 64'h8010_0008, 3'd3, 8'hFF, 64'hDEAD_BEEF));
    exp_grant.push_back(gv(1'b0, 64'h8000_0004, 3'd2, 8'h00, 64'h0));
    step();
    chk("d_first", 160'({cbus_owner, cbus_strobe}), 160'({1'b1, 8'hFF}));
    respond(2, 64'hA5A5_0000_5A5A, 1'b1);
    dreq_valid = 1'b0;
    chk("idle_after_d", 160'(cbus_valid), 160'(0));
    step();
    chk("i_after_idle", 160'({cbus_valid, cbus_owner}), 160'({1'b1, 1'b0}));
    // Upstream address change during BUSY_I is ignored
    ireq_addr = 64'h8000_0100;
    step();
    chk("busy_hold_addr", 160'(cbus_addr), 160'(64'h8000_0004));
    respond(2, 64'h1111, 1'b0);
    ireq_valid = 1'b0;

    // Continuous contention, k = 1: D, D, I, D, D, I with one idle cycle between
    ireq_valid = 1'b1; ireq_addr = 64'h2000;
    dreq_valid = 1'b1; dreq_addr = 64'h1000; dreq_size = 3'd3;
    dreq_data = '0; dreq_strobe = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (own_seq[i]) exp_grant.push_back(gv(1'b1, 64'h1000, 3'd3, 8'h00, 64'h0));
      else            exp_grant.push_back(gv(1'b0, 64'h2000, 3'd2, 8'h00, 64'h0));
    end
    for (int i = 0; i < 6; i++) begin
      wait_grant(n);
      chk("grant_gap", 160'(n), 160'(1));
      respond(1, 64'h100 + 64'(i), own_seq[i]);
      if (i == 5) begin
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
      end
      chk("post_idle", 160'(cbus_valid), 160'(0));
    end
    step();

    // Reset during BUSY_D, then a stray completion
    ireq_valid = 1'b1; ireq_addr = 64'h3000;
    dreq_valid = 1'b1; dreq_addr = 64'h4000; dreq_size = 3'd3;
    dreq_data = 64'h77; dreq_strobe = 8'h0F;
    exp_grant.push_back(gv(1'b1, 64'h4000, 3'd3, 8'h0F, 64'h77));
    step();
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    chk("busy_d_valid", 160'(cbus_valid), 160'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_busy_drop", gv(cbus_valid, cbus_addr, cbus_size, cbus_strobe, cbus_wdata), 160'(0));
    step(); step();
    cbus_rdata = 64'h99; cbus_data_ok = 1'b1;
    #1;
    chk("stray_ok", 160'({iresp_data_ok, dresp_data_ok}), 160'(0));
    step();
    cbus_data_ok = 1'b0;
    chk("stray_no_grant", 160'(cbus_valid), 160'(0));

    // Counter cleared by reset: contention yields D, D, I
    ireq_valid = 1'b1; dreq_valid = 1'b1; dreq_strobe = 8'h00; dreq_data = '0;
    exp_grant.push_back(gv(1'b1, 64'h4000, 3'd3, 8'h00, 64'h0));
    exp_grant.push_back(gv(1'b1, 64'h4000, 3'd3, 8'h00, 64'h0));
    exp_grant.push_back(gv(1'b0, 64'h3000, 3'd2, 8'h00, 64'h0));
    for (int i = 0; i < 3; i++) begin
      wait_grant(n);
      respond(1, 64'h200 + 64'(i), own_seq[i]);
      if (i == 2) begin
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
      end
    end
    step(); step();

    chk("grant_q_left", 160'(exp_grant.size()), 160'(0));
    chk("resp_q_left", 160'(exp_resp.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
